id_gaussian: RTL and testbench



---
 rtl/id_gaussian.sv | 97 +++++++++
 tb/tb_id_gaussian.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/id_gaussian.sv
// Dual-channel Gaussian RNG: per-lane xorshift64 state feeding an Irwin-Hall (n=4)
// sum, scaled by sqrt(3) and emitted as truncated IEEE-754 single precision.

module id_gaussian_lane #(
  parameter logic [31:0] INIT_HI = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [22:0] i_seed,
  output logic [31:0] o_g
);
  logic        [63:0] r_s;
  logic        [31:0] r_g;
  logic        [22:0] w_seed;
  logic        [63:0] w_x1, w_x2, w_x3;
  logic        [17:0] w_sum;
  logic signed [18:0] w_d;
  logic signed [35:0] w_d36, w_p, w_pn;
  logic        [33:0] w_m, w_norm;
  logic        [5:0]  w_k;
  logic        [7:0]  w_exp;
  logic        [31:0] w_f;
  logic               w_unused;

  assign w_seed = (i_seed == 23'h0) ? 23'h1 : i_seed;

  assign w_x1 = r_s ^ (r_s << 13);
  assign w_x2 = w_x1 ^ (w_x1 >> 7);
  assign w_x3 = w_x2 ^ (w_x2 << 17);

  assign w_sum = 18'(r_s[15:0]) + 18'(r_s[31:16]) + 18'(r_s[47:32]) + 18'(r_s[63:48]);
  assign w_d   = $signed({1'b0, w_sum}) - 19'sd131072;
  assign w_d36 = {{17{w_d[18]}}, w_d};
  // 113512 = sqrt(3) in Q1.16; |P| < 2^34 so 36 bits never overflow
  assign w_p   = w_d36 * 36'sd113512;
  assign w_pn  = -w_p;
  assign w_m   = w_p[35] ? w_pn[33:0] : w_p[33:0];

  always_comb begin
    w_k = 6'd0;
    for (int i = 0; i < 34; i++)
      if (w_m[i]) w_k = 6'(i);
  end

  // Left-justify the leading one at bit 33; the 23 bits under it are the mantissa
  assign w_norm = w_m << (6'd33 - w_k);
  assign w_exp  = 8'(w_k) + 8'd95;
  assign w_f    = (w_m == 34'h0) ? 32'h0 : {w_p[35], w_exp, w_norm[32:10]};

  assign w_unused = ^{w_norm[33], w_norm[9:0], w_pn[35:34], w_p[34]};

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_s <= {INIT_HI, 9'h0, 23'h1};
      r_g <= 32'h0;
    end else if (en) begin
      r_s <= {INIT_HI, 9'h0, w_seed};
    end else begin
      r_s <= w_x3;
      r_g <= w_f;
    end
  end

  assign o_g = r_g;
endmodule

module id_gaussian (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [22:0] seed1,
  input  logic [22:0] seed2,
  output logic [31:0] G1,
  output logic [31:0] G2
);
  localparam int NUM_LANES = 2;
  localparam logic [NUM_LANES-1:0][31:0] LANE_INIT = {32'h7F4A7C15, 32'h9E3779B9};

  logic [NUM_LANES-1:0][22:0] w_seed;
  logic [NUM_LANES-1:0][31:0] w_g;

  assign w_seed = {seed2, seed1};

  for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
    id_gaussian_lane #(.INIT_HI(LANE_INIT[gi])) u_lane (
      .clk   (clk),
      .rst   (rst),
      .en    (en),
      .i_seed(w_seed[gi]),
      .o_g   (w_g[gi])
    );
  end

  assign G1 = w_g[0];
  assign G2 = w_g[1];
endmodule

// File: tb/tb_id_gaussian.sv
// Bench for id_gaussian: directed seed vectors, reset/hold/reload sequences, and a
// long random-seeded run against an arithmetic model with output statistics.

module tb_id_gaussian;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en  = 1'b0;
  logic [22:0] seed1 = 23'h0;
  logic [22:0] seed2 = 23'h0;
  logic [31:0] G1, G2;

  int checks   = 0;
  int failures = 0;

  logic [63:0] m1, m2;
  real sum_g, sumsq_g, max_abs;
  int  max_exp;

  localparam logic [31:0] HI1 = 32'h9E3779B9;
  localparam logic [31:0] HI2 = 32'h7F4A7C15;

  always #5 clk = ~clk;

  id_gaussian dut (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .seed1(seed1),
    .seed2(seed2),
    .G1   (G1),
    .G2   (G2)
  );

  typedef struct {
    logic [22:0] s1;
    logic [22:0] s2;
    logic [31:0] e1;
    logic [31:0] e2;
  } vec_t;

  function automatic logic [63:0] init_m(input logic [31:0] hi, input logic [22:0] s);
    logic [22:0] sp;
    sp = (s == 0) ? 23'd1 : s;
    return {hi, 9'h0, sp};
  endfunction

  function automatic logic [63:0] xs_m(input logic [63:0] x);
    logic [63:0] y;
    y = x;
    y = y ^ (y << 13);
    y = y ^ (y >> 7);
    y = y ^ (y << 17);
    return y;
  endfunction

  // Value = (sum - 2^17) * 113512 / 2^32, encoded by searching the top set bit
  function automatic logic [31:0] gauss_m(input logic [63:0] x);
    longint s, p;
    longint unsigned m;
    int k;
    logic [31:0] mant;
    logic [7:0] e;
    s = longint'(x[15:0]) + longint'(x[31:16]) + longint'(x[47:32]) + longint'(x[63:48]);
    p = (s - 131072) * 113512;
    if (p == 0) return 32'h0;
    m = (p < 0) ? longint'(-p) : p;
    k = 0;
    while ((m >> (k + 1)) != 0) k++;
    e = 8'(95 + k);
    if (k >= 23) mant = 32'(m >> (k - 23));
    else         mant = 32'(m << (23 - k));
    return {(p < 0), e, mant[22:0]};
  endfunction

  function automatic real f2r(input logic [31:0] b);
    real v;
    if (b[30:0] == 0) return 0.0;
    v = (1.0 + real'(b[22:0]) / 8388608.0) * (2.0 ** (real'(int'(b[30:23])) - 127.0));
    return b[31] ? -v : v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic chk_ok(input string name, input bit ok, input real act);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s value=%f out of range", name, act);
    end
  endtask

  task automatic load(input logic [22:0] s1, input logic [22:0] s2);
    seed1 = s1;
    seed2 = s2;
    en = 1'b1;
    tick();
    en = 1'b0;
    m1 = init_m(HI1, s1);
    m2 = init_m(HI2, s2);
  endtask

  task automatic run_cmp(input string name, input int n, input bit stats);
    logic [31:0] e1, e2;
    real v;
    for (int i = 0; i < n; i++) begin
      e1 = gauss_m(m1);
      e2 = gauss_m(m2);
      m1 = xs_m(m1);
      m2 = xs_m(m2);
      tick();
      chk({name, "_g1"}, G1, e1);
      chk({name, "_g2"}, G2, e2);
      if (stats) begin
        v = f2r(G2);
        sum_g   += v;
        sumsq_g += v * v;
        if ((v < 0 ? -v : v) > max_abs) max_abs = (v < 0 ? -v : v);
        if (int'(G2[30:23]) > max_exp) max_exp = int'(G2[30:23]);
      end
    end
  endtask

  // Occasional mid-stream reseeds from random values
  task automatic run_rand(input int n);
    logic [31:0] e1, e2;
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 49) == 0) begin
        load(23'($urandom), 23'($urandom));
      end else begin
        e1 = gauss_m(m1);
        e2 = gauss_m(m2);
        m1 = xs_m(m1);
        m2 = xs_m(m2);
        tick();
        chk("rand_g1", G1, e1);
        chk("rand_g2", G2, e2);
      end
    end
  endtask

  initial begin
    vec_t tbl[6];
    logic [31:0] h1, h2;
    real mean, var_g;

    tbl[0] = '{s1: 23'd59408, s2: 23'd1185,  e1: 32'h00000000, e2: 32'hBFDDB400};
    tbl[1] = '{s1: 23'd26640, s2: 23'd33953, e1: 32'hBF5DB400, e2: 32'hBF5DB400};
    tbl[2] = '{s1: 23'd92175, s2: 23'd50337, e1: 32'hBF5DB400, e2: 32'hBEDDB400};
    tbl[3] = '{s1: 23'd63504, s2: 23'd99488, e1: 32'h3DDDB400, e2: 32'hBF5DB400};
    tbl[4] = '{s1: 23'd0,     s2: 23'd1185,  e1: 32'hBFC8F81D, e2: 32'hBFDDB400};
    tbl[5] = '{s1: 23'd1,     s2: 23'd1185,  e1: 32'hBFC8F81D, e2: 32'hBFDDB400};

    // Reset clears outputs, then free-run from init(0)
    rst = 1'b0;
    tick();
    chk("reset_g1", G1, 32'h0);
    chk("reset_g2", G2, 32'h0);
    rst = 1'b1;
    m1 = init_m(HI1, 23'd0);
    m2 = init_m(HI2, 23'd0);
    run_cmp("freerun0", 20, 1'b0);

    // Reset while free-running restarts from init(0)
    rst = 1'b0;
    tick();
    chk("rerst_g1", G1, 32'h0);
    chk("rerst_g2", G2, 32'h0);
    rst = 1'b1;
    m1 = init_m(HI1, 23'd0);
    m2 = init_m(HI2, 23'd0);
    run_cmp("after_rerst", 10, 1'b0);

    // Directed first-sample vectors (D=0, D=+-2^k, seed 0 vs 1)
    for (int i = 0; i < 6; i++) begin
      load(tbl[i].s1, tbl[i].s2);
      tick();
      chk($sformatf("vec%0d_g1", i), G1, tbl[i].e1);
      chk($sformatf("vec%0d_g2", i), G2, tbl[i].e2);
    end

    // en held high: outputs frozen, first sample after release is gauss(init)
    h1 = G1;
    h2 = G2;
    seed1 = 23'd777;
    seed2 = 23'd4242;
    en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("hold_g1", G1, h1);
      chk("hold_g2", G2, h2);
    end
    en = 1'b0;
    tick();
    chk("release_g1", G1, gauss_m(init_m(HI1, 23'd777)));
    chk("release_g2", G2, gauss_m(init_m(HI2, 23'd4242)));

    // Seed 0 behaves exactly like seed 1
    load(23'd0, 23'd0);
    m1 = init_m(HI1, 23'd1);
    m2 = init_m(HI2, 23'd1);
    run_cmp("seed0", 30, 1'b0);

    // Long run with statistics on channel 2
    sum_g = 0.0; sumsq_g = 0.0; max_abs = 0.0; max_exp = 0;
    load(23'd4357, 23'd232);
    run_cmp("main", 50000, 1'b1);
    mean  = sum_g / 50000.0;
    var_g = sumsq_g / 50000.0 - mean * mean;
    chk_ok("stat_mean", (mean < 0.02) && (mean > -0.02), mean);
    chk_ok("stat_var", (var_g > 0.97) && (var_g < 1.03), var_g);
    chk_ok("stat_max", max_abs <= 3.4641, max_abs);
    chk_ok("stat_exp", max_exp <= 128, real'(max_exp));

    // Reload with same seeds mid-run: stream repeats from its first sample
    load(23'd4357, 23'd232);
    run_cmp("repulse", 20, 1'b0);

    // Random seeds with random mid-stream reloads
    load(23'($urandom), 23'($urandom));
    run_rand(3000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
